lsu: RTL

Load/store unit for the RV32I core. Sits between the execute stage and the byte-banked data `ram`. It accepts one memory operation at a time from execute and drives the RAM's data-side read and write ports with word address, byte enables and replicated store data. It returns sign- or zero-extended load data with a done pulse.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_if.sv | 34 +++
 rtl/lsu_load_align.sv | 36 +++
 rtl/lsu.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit: funct3 codes,
// FSM state encoding, the latched request record and op legality checks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } lsu_state_t;

  // Only what the READ state still needs once the bus inputs have moved on.
  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] offset;
  } lsu_req_t;

  function automatic logic op_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return |off;
      default: return 1'b0;
    endcase
  endfunction

  // Clears the low address bits a halfword or word access cannot use.
  function automatic logic [1:0] eff_offset(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return {off[1], 1'b0};
      2'b10:   return 2'b00;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side request/response and RAM data-side port bundle of the LSU.
interface lsu_if #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
);
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_is_store;
  logic [2:0]            i_funct3;
  logic [ADDR_WIDTH:0]   i_addr;
  logic [DATA_WIDTH:0]   i_store_data;
  logic                  o_done;
  logic                  o_fault;
  logic [DATA_WIDTH:0]   o_load_data;
  logic                  o_mem_read_req;
  logic [ADDR_WIDTH:0]   o_mem_read_addr;
  logic [DATA_WIDTH:0]   i_mem_read_data;
  logic                  o_mem_write_enable;
  logic [3:0]            o_mem_byte_enable;
  logic [ADDR_WIDTH:0]   o_mem_write_addr;
  logic [DATA_WIDTH:0]   o_mem_write_data;

  modport slave (
    input  i_valid, i_is_store, i_funct3, i_addr, i_store_data, i_mem_read_data,
    output o_ready, o_done, o_fault, o_load_data, o_mem_read_req, o_mem_read_addr,
           o_mem_write_enable, o_mem_byte_enable, o_mem_write_addr, o_mem_write_data
  );

  modport master (
    output i_valid, i_is_store, i_funct3, i_addr, i_store_data, i_mem_read_data,
    input  o_ready, o_done, o_fault, o_load_data, o_mem_read_req, o_mem_read_addr,
           o_mem_write_enable, o_mem_byte_enable, o_mem_write_addr, o_mem_write_data
  );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the addressed byte/half out of the RAM
// word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 31
) (
  input  logic [DATA_WIDTH:0] i_word,
  input  logic [1:0]          i_offset,
  input  logic [2:0]          i_funct3,
  output logic [DATA_WIDTH:0] o_data
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    case (i_offset)
      2'd0:    byte_sel = i_word[7:0];
      2'd1:    byte_sel = i_word[15:8];
      2'd2:    byte_sel = i_word[23:16];
      default: byte_sel = i_word[31:24];
    endcase
    half_sel = i_offset[1] ? i_word[31:16] : i_word[15:0];

    case (i_funct3)
      F3_B:    o_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   o_data = {24'd0, byte_sel};
      F3_H:    o_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   o_data = {16'd0, half_sel};
      F3_W:    o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one op at a time, IDLE->READ/WRITE->DONE, all outputs
// registered. Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  lsu_if.slave bus
);

  lsu_state_t          state_q, state_d;
  lsu_req_t            req_q, req_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                fault_q, fault_d;
  logic [DATA_WIDTH:0] load_data_q, load_data_d;
  logic                rd_req_q, rd_req_d;
  logic [ADDR_WIDTH:0] rd_addr_q, rd_addr_d;
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [ADDR_WIDTH:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH:0] wr_data_q, wr_data_d;

  logic [1:0]          acc_off;
  logic                acc_fault;
  logic [ADDR_WIDTH:0] acc_word;
  logic [DATA_WIDTH:0] aligned;

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_word   (bus.i_mem_read_data),
    .i_offset (req_q.offset),
    .i_funct3 (req_q.funct3),
    .o_data   (aligned)
  );

  always_comb begin
    acc_word = {2'b00, bus.i_addr[ADDR_WIDTH:2]};
`ifdef LSU_MISALIGN_TRAP_EN
    acc_off   = bus.i_addr[1:0];
    acc_fault = op_illegal(bus.i_is_store, bus.i_funct3) | misaligned(bus.i_funct3, bus.i_addr[1:0]);
`else
    acc_off   = eff_offset(bus.i_funct3, bus.i_addr[1:0]);
    acc_fault = op_illegal(bus.i_is_store, bus.i_funct3);
`endif

    state_d     = state_q;
    req_d       = req_q;
    load_data_d = load_data_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    rd_req_d    = 1'b0;
    rd_addr_d   = '0;
    we_d        = 1'b0;
    be_d        = 4'b0000;
    wr_addr_d   = '0;
    wr_data_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          req_d.funct3 = bus.i_funct3;
          req_d.offset = acc_off;
          if (acc_fault) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else if (!bus.i_is_store) begin
            state_d   = ST_READ;
            rd_req_d  = 1'b1;
            rd_addr_d = acc_word;
          end else begin
            state_d   = ST_WRITE;
            we_d      = 1'b1;
            wr_addr_d = acc_word;
            case (bus.i_funct3)
              F3_B: begin
                be_d      = 4'b0001 << acc_off;
                wr_data_d = {4{bus.i_store_data[7:0]}};
              end
              F3_H: begin
                be_d      = 4'b0011 << acc_off;
                wr_data_d = {2{bus.i_store_data[15:0]}};
              end
              default: begin
                be_d      = 4'b1111;
                wr_data_d = bus.i_store_data;
              end
            endcase
          end
        end
      end
      ST_READ: begin
        load_data_d = aligned;
        state_d     = ST_DONE;
        done_d      = 1'b1;
      end
      ST_WRITE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // Everything, outputs included, holds while clk_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      we_q        <= 1'b0;
      be_q        <= 4'b0000;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else if (clk_en) begin
      state_q     <= state_d;
      req_q       <= req_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign bus.o_ready            = ready_q;
  assign bus.o_done             = done_q;
  assign bus.o_fault            = fault_q;
  assign bus.o_load_data        = load_data_q;
  assign bus.o_mem_read_req     = rd_req_q;
  assign bus.o_mem_read_addr    = rd_addr_q;
  assign bus.o_mem_write_enable = we_q;
  assign bus.o_mem_byte_enable  = be_q;
  assign bus.o_mem_write_addr   = wr_addr_q;
  assign bus.o_mem_write_data   = wr_data_q;

endmodule
